// File: rtl/brg_sram_pkg.sv
// brg_sram_pkg: tile geometry, hard-macro tie-off values and the
// zero-init FSM state type shared by the tiled SRAM files.
package brg_sram_pkg;

   localparam int TILE_DEPTH  = 1024;
   localparam int TILE_WIDTH  = 8;
   localparam int TILE_ADDR_W = 10;

   // Macro tie-offs: margin settings for normal operation, retention off,
   // test mode disabled (TEN is active-low).
   localparam logic [2:0] MACRO_EMA   = 3'd3;
   localparam logic [1:0] MACRO_EMAW  = 2'd1;
   localparam logic       MACRO_EMAS  = 1'b0;
   localparam logic       MACRO_RET1N = 1'b1;
   localparam logic       MACRO_TEN   = 1'b1;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } init_state_e;

endpackage

// File: rtl/brg_sram_tiled_if.sv
// brg_sram_tiled_if: request/response bundle of the tiled SRAM.
// master = requester, slave = memory.
interface brg_sram_tiled_if #(
   parameter int width_p = 32,
   parameter int els_p   = 2048
);
   localparam int addr_width_lp = $clog2(els_p);

   logic                     v_i;
   logic                     ready_o;
   logic                     w_i;
   logic [addr_width_lp-1:0] addr_i;
   logic [width_p-1:0]       data_i;
   logic [width_p/8-1:0]     w_mask_i;
   logic                     data_v_o;
   logic [width_p-1:0]       data_o;

   modport master (
      output v_i, w_i, addr_i, data_i, w_mask_i,
      input  ready_o, data_v_o, data_o
   );

   modport slave (
      input  v_i, w_i, addr_i, data_i, w_mask_i,
      output ready_o, data_v_o, data_o
   );

endinterface

// File: rtl/brg_sram_1024x8_macro.sv
// brg_sram_1024x8_macro: behavioural stand-in for the 28nm 1024x8
// single-port hard macro (active-low CEN/WEN, registered read port).
// Margin, retention and test pins exist only so the tie-offs are visible.
module brg_sram_1024x8_macro (
   input  logic       CLK,
   input  logic       CEN,
   input  logic       WEN,
   input  logic [9:0] A,
   input  logic [7:0] D,
   output logic [7:0] Q,
   input  logic [2:0] EMA,
   input  logic [1:0] EMAW,
   input  logic       EMAS,
   input  logic       RET1N,
   input  logic       TEN,
   input  logic       BEN,
   input  logic       TCEN,
   input  logic       TWEN,
   input  logic [9:0] TA,
   input  logic [7:0] TD,
   input  logic       SE,
   input  logic       SI
);
   logic [7:0] r_mem [1024];
   logic       w_unused_tieoffs;

   assign w_unused_tieoffs = ^{EMA, EMAW, EMAS, RET1N, TEN, BEN, TCEN, TWEN, TA, TD, SE, SI};

   // Single port: write when enabled with WEN low, otherwise read into Q.
   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!WEN) r_mem[A] <= D;
         else      Q        <= r_mem[A];
      end
   end

endmodule

// File: rtl/brg_sram_init_ctrl.sv
// brg_sram_init_ctrl: after reset, sweeps a 10-bit address 0..1023 so the
// top can write zero into every tile, then parks in READY until reset.
// Only instantiated when BRG_SRAM_ZERO_INIT_EN is defined.
module brg_sram_init_ctrl
   import brg_sram_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   output logic                   init_active,
   output logic [TILE_ADDR_W-1:0] init_addr
);
   init_state_e            r_state, w_state_nxt;
   logic [TILE_ADDR_W-1:0] r_cnt, w_cnt_nxt;

   // State and sweep counter registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: leave INIT once address 1023 has been written.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      init_active = 1'b0;
      case (r_state)
         INIT: begin
            init_active = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == TILE_ADDR_W'(TILE_DEPTH - 1)) w_state_nxt = READY;
         end
         default: ;
      endcase
   end

   assign init_addr = r_cnt;

endmodule

// File: rtl/brg_sram_tiled.sv
// brg_sram_tiled: width_p x els_p single-port SRAM built from a
// rows x cols array of 1024x8 macros; one request per cycle, read data
// valid one cycle after acceptance and held until the next read.
// Optional macro BRG_SRAM_ZERO_INIT_EN: zero the whole array after reset.
module brg_sram_tiled
   import brg_sram_pkg::*;
#(
   parameter int width_p = 32,
   parameter int els_p   = 2048
) (
   input  logic             clk_i,
   input  logic             reset_i,
   brg_sram_tiled_if.slave  bus
);
   localparam int addr_width_lp = $clog2(els_p);
   localparam int cols_lp       = width_p / 8;
   localparam int rows_lp       = els_p / 1024;
   localparam int row_w_lp      = (rows_lp > 1) ? $clog2(rows_lp) : 1;

   logic                              w_init_active;
   logic [TILE_ADDR_W-1:0]            w_init_addr;
   logic                              w_accept;
   logic [row_w_lp-1:0]               w_row_sel;
   logic [TILE_ADDR_W-1:0]            w_tile_addr;
   logic [rows_lp-1:0][width_p-1:0]   w_q;
   logic [width_p-1:0]                w_rdata;
   logic                              r_ready;
   logic                              r_rd_v;
   logic [row_w_lp-1:0]               r_row_q;
   logic [width_p-1:0]                r_hold;

`ifdef BRG_SRAM_ZERO_INIT_EN
   brg_sram_init_ctrl u_init (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .init_active (w_init_active),
      .init_addr   (w_init_addr)
   );
`else
   assign w_init_active = 1'b0;
   assign w_init_addr   = '0;
`endif

   generate
      if (rows_lp > 1) begin : g_rsel
         assign w_row_sel = bus.addr_i[addr_width_lp-1:TILE_ADDR_W];
      end else begin : g_rsel1
         assign w_row_sel = '0;
      end
   endgenerate

   assign w_accept    = bus.v_i & r_ready;
   assign w_tile_addr = w_init_active ? w_init_addr : bus.addr_i[TILE_ADDR_W-1:0];

   // During init every tile is enabled and written with zero; otherwise only
   // the addressed row is enabled, and a byte writes only if its mask bit is set.
   generate
      for (genvar r = 0; r < rows_lp; r++) begin : g_row
         for (genvar c = 0; c < cols_lp; c++) begin : g_col
            logic                  w_cen_n, w_wen_n;
            logic [TILE_WIDTH-1:0] w_d;
            assign w_cen_n = ~(w_init_active | (w_accept & (w_row_sel == row_w_lp'(r))));
            assign w_wen_n = ~(w_init_active | (bus.w_i & bus.w_mask_i[c]));
            assign w_d     = w_init_active ? '0 : bus.data_i[8*c +: 8];
            brg_sram_1024x8_macro u_tile (
               .CLK   (clk_i),
               .CEN   (w_cen_n),
               .WEN   (w_wen_n),
               .A     (w_tile_addr),
               .D     (w_d),
               .Q     (w_q[r][8*c +: 8]),
               .EMA   (MACRO_EMA),
               .EMAW  (MACRO_EMAW),
               .EMAS  (MACRO_EMAS),
               .RET1N (MACRO_RET1N),
               .TEN   (MACRO_TEN),
               .BEN   (1'b0),
               .TCEN  (1'b0),
               .TWEN  (1'b0),
               .TA    ('0),
               .TD    ('0),
               .SE    (1'b0),
               .SI    (1'b0)
            );
         end
      end
   endgenerate

   // Ready flag, read-valid pulse and the row select that steers the output mux.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_ready <= 1'b0;
         r_rd_v  <= 1'b0;
         r_row_q <= '0;
      end else begin
         r_ready <= ~w_init_active;
         r_rd_v  <= w_accept & ~bus.w_i;
         if (w_accept & ~bus.w_i) r_row_q <= w_row_sel;
      end
   end

   assign w_rdata = w_q[r_row_q];

   // Hold register keeps the last read word so later writes never disturb data_o.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)     r_hold <= '0;
      else if (r_rd_v) r_hold <= w_rdata;
   end

   assign bus.ready_o  = r_ready;
   assign bus.data_v_o = r_rd_v;
   assign bus.data_o   = r_rd_v ? w_rdata : r_hold;

endmodule

// File: tb/tb_brg_sram_tiled.sv
// tb_brg_sram_tiled: directed checks of brg_sram_tiled (32 x 2048) in
// either build of BRG_SRAM_ZERO_INIT_EN.
module tb_brg_sram_tiled;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   n;

`ifdef BRG_SRAM_ZERO_INIT_EN
   localparam int EXP_RDY = 1025;
`else
   localparam int EXP_RDY = 1;
`endif

   always #5 clk = ~clk;

   brg_sram_tiled_if #(.width_p(32), .els_p(2048)) bus ();

   brg_sram_tiled #(.width_p(32), .els_p(2048)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m,
                     input string tag);
      bus.v_i = 1'b1; bus.w_i = 1'b1; bus.addr_i = a; bus.data_i = d; bus.w_mask_i = m;
      tick();
      bus.v_i = 1'b0;
      chk({tag, " no data_v"}, 32'(bus.data_v_o), 32'd0);
   endtask

   task automatic rd(input logic [10:0] a, input logic [31:0] exp, input string tag);
      bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = a;
      tick();
      bus.v_i = 1'b0;
      chk({tag, " data_v"}, 32'(bus.data_v_o), 32'd1);
      chk({tag, " data"}, bus.data_o, exp);
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (bus.ready_o !== 1'b1 && cnt < 3000) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      bus.v_i = 1'b0; bus.w_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.w_mask_i = '0;

      // reset state
      #12;
      chk("reset ready", 32'(bus.ready_o), 32'd0);
      chk("reset data_v", 32'(bus.data_v_o), 32'd0);
      chk("reset data", bus.data_o, 32'd0);

      // release and measure ready latency
      @(posedge clk); #1; rst = 1'b0;
      wait_ready(n);
      chk("ready latency", n, EXP_RDY);

`ifdef BRG_SRAM_ZERO_INIT_EN
      rd(11'h7FF, 32'h0000_0000, "init zero 7ff");
`endif

      // full write, back-to-back read
      wr(11'h005, 32'hDEAD_BEEF, 4'b1111, "wr full");
      rd(11'h005, 32'hDEAD_BEEF, "rd full");

      // byte masking
      wr(11'h005, 32'h1122_3344, 4'b0101, "wr mask");
      rd(11'h005, 32'hDE22_BE44, "rd mask");

      // row isolation
      wr(11'h405, 32'hCAFE_F00D, 4'b1111, "wr row1");
      rd(11'h005, 32'hDE22_BE44, "rd row0");
      rd(11'h405, 32'hCAFE_F00D, "rd row1");

      // all-zero mask writes nothing
      wr(11'h005, 32'hFFFF_FFFF, 4'b0000, "wr nomask");
      rd(11'h005, 32'hDE22_BE44, "rd nomask");

      // hold across a write to the same address
      rd(11'h405, 32'hCAFE_F00D, "hold rd");
      wr(11'h405, 32'h0000_0000, 4'hF, "hold wr");
      chk("hold data after wr", bus.data_o, 32'hCAFE_F00D);
      tick();
      chk("hold idle data_v", 32'(bus.data_v_o), 32'd0);
      chk("hold idle data", bus.data_o, 32'hCAFE_F00D);
      rd(11'h405, 32'h0000_0000, "rd after hold");

      // reset with a read outstanding drops data_v and clears data
      bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 11'h005;
      tick();
      bus.v_i = 1'b0;
      chk("pre-reset data_v", 32'(bus.data_v_o), 32'd1);
      chk("pre-reset data", bus.data_o, 32'hDE22_BE44);
      rst = 1'b1;
      #1;
      chk("async reset ready", 32'(bus.ready_o), 32'd0);
      chk("async reset data_v", 32'(bus.data_v_o), 32'd0);
      chk("async reset data", bus.data_o, 32'd0);
      tick();
      @(posedge clk); #1; rst = 1'b0;

`ifdef BRG_SRAM_ZERO_INIT_EN
      // requests during init are ignored; reset at init cycle 500 restarts it
      bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 11'h005;
      repeat (500) tick();
      chk("mid-init ready", 32'(bus.ready_o), 32'd0);
      chk("mid-init ignored v", 32'(bus.data_v_o), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid-init reset ready", 32'(bus.ready_o), 32'd0);
      chk("mid-init reset data", bus.data_o, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      bus.v_i = 1'b0;
      wait_ready(n);
      chk("re-init latency", n, 1025);
      rd(11'h005, 32'h0000_0000, "rezeroed 005");
      rd(11'h405, 32'h0000_0000, "rezeroed 405");
`else
      wait_ready(n);
      chk("re-ready latency", n, 1);
      rd(11'h005, 32'hDE22_BE44, "kept after reset");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
